// File: rtl/csc_multimode_pipe.sv
// ---------------------------------------------------------------------------
// csc_multimode_pipe
//   Pipelined multi-mode colour-space converter: bypass, RGB->YCbCr,
//   YCbCr->RGB or RGB->Gray. The mode is chosen once per frame, at the rising
//   edge of per_frame_vsync. Every result is clamped to [0, 2^DW-1]. The
//   vsync/href/clken signals are delayed to match the 3-clk data latency.
//
//   Optional feature macro: CSC_FRAME_STATS_EN
//     When defined, a per-frame count of valid output pixels that had at least
//     one clamped channel is published on stat_sat_cnt at each falling edge of
//     post_frame_vsync. When undefined, stat_sat_cnt is tied to zero.
//
// Ports
//   clk, rst_n                    pixel clock, synchronous active-low reset
//   per_frame_vsync/href/clken    input sync and pixel enable
//   per_img_mode[3:0]             0 bypass, 1 RGB->YCbCr, 2 YCbCr->RGB,
//                                 3 RGB->Gray; 4..15 are treated as bypass
//   per_img_c0/c1/c2[DW-1:0]      input components (R,G,B or Y,Cb,Cr)
//   post_frame_vsync/href/clken   sync inputs delayed by 3 clk
//   post_img_mode[3:0]            mode that produced the current output pixel
//   post_img_c0/c1/c2[DW-1:0]     converted components, 0 outside valid pixels
//   stat_sat_cnt[15:0]            clamped-pixel count of the last frame
// ---------------------------------------------------------------------------
module csc_multimode_pipe #(
  parameter int DW           = 8,
  parameter int MODE_DEFAULT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          per_frame_vsync,
  input  logic          per_frame_href,
  input  logic          per_frame_clken,
  input  logic [3:0]    per_img_mode,
  input  logic [DW-1:0] per_img_c0,
  input  logic [DW-1:0] per_img_c1,
  input  logic [DW-1:0] per_img_c2,
  output logic          post_frame_vsync,
  output logic          post_frame_href,
  output logic          post_frame_clken,
  output logic [3:0]    post_img_mode,
  output logic [DW-1:0] post_img_c0,
  output logic [DW-1:0] post_img_c1,
  output logic [DW-1:0] post_img_c2,
  output logic [15:0]   stat_sat_cnt
);

  localparam int IW = DW + 11;
  localparam logic signed [IW-1:0] OFS    = IW'(1 << (DW - 1));
  localparam logic signed [IW-1:0] OFS_SH = IW'((1 << (DW - 1)) << 8);
  localparam logic signed [IW-1:0] RND    = IW'(128);
  localparam logic signed [IW-1:0] MAXV   = IW'((1 << DW) - 1);

  function automatic logic [3:0] legal_mode(input logic [3:0] m);
    return (m > 4'd3) ? 4'd0 : m;
  endfunction

  function automatic logic signed [IW-1:0] round_shift(input logic signed [IW-1:0] s);
    return (s + RND) >>> 8;
  endfunction

  function automatic logic [DW-1:0] saturate(input logic signed [IW-1:0] v);
    if (v[IW-1]) return '0;
    if (v > MAXV) return '1;
    return v[DW-1:0];
  endfunction

  // Frame-start mode latch; the pixel on the frame-start cycle already uses
  // the newly requested mode.
  logic       vsync_q;
  logic [3:0] act_mode;
  logic [3:0] cur_mode;
  logic       frame_start;

  assign frame_start = per_frame_vsync & ~vsync_q;

  always_comb begin
    cur_mode = frame_start ? legal_mode(per_img_mode) : act_mode;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vsync_q  <= 1'b0;
      act_mode <= legal_mode(4'(MODE_DEFAULT));
    end else begin
      vsync_q <= per_frame_vsync;
      if (frame_start) act_mode <= legal_mode(per_img_mode);
    end
  end

  // All modes share one 3x3 matrix form: out_k = (sum_j cf[k][j]*x[j] + add[k]
  // + 128) >>> 8. Offsets and the YCbCr->RGB luma term are pre-shifted by 8 so
  // they survive the shift exactly; bypass uses 256 on the diagonal.
  logic signed [IW-1:0] x   [3];
  logic signed [IW-1:0] cf  [3][3];
  logic signed [IW-1:0] add [3];

  always_comb begin
    x[0] = $signed(IW'(per_img_c0));
    x[1] = $signed(IW'(per_img_c1));
    x[2] = $signed(IW'(per_img_c2));
    for (int k = 0; k < 3; k++) begin
      add[k] = '0;
      for (int j = 0; j < 3; j++) cf[k][j] = '0;
    end
    case (cur_mode)
      4'd1: begin
        cf[0] = '{IW'(77),  IW'(150),  IW'(29)};
        cf[1] = '{IW'(-43), IW'(-85),  IW'(128)};
        cf[2] = '{IW'(128), IW'(-107), IW'(-21)};
        add   = '{IW'(0), OFS_SH, OFS_SH};
      end
      4'd2: begin
        x[1]  = x[1] - OFS;
        x[2]  = x[2] - OFS;
        cf[0] = '{IW'(0), IW'(0),   IW'(359)};
        cf[1] = '{IW'(0), IW'(-88), IW'(-183)};
        cf[2] = '{IW'(0), IW'(454), IW'(0)};
        add   = '{x[0] <<< 8, x[0] <<< 8, x[0] <<< 8};
      end
      4'd3: begin
        for (int k = 0; k < 3; k++) cf[k] = '{IW'(77), IW'(150), IW'(29)};
      end
      default: begin
        cf[0] = '{IW'(256), IW'(0),   IW'(0)};
        cf[1] = '{IW'(0),   IW'(256), IW'(0)};
        cf[2] = '{IW'(0),   IW'(0),   IW'(256)};
      end
    endcase
  end

  // ---- S1: signed products ----
  logic signed [IW-1:0] prod_p0 [3][3];
  logic signed [IW-1:0] add_p0  [3];
  logic [3:0]           mode_p0;
  logic [2:0]           sync_p0;
  logic                 vld_p0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        add_p0[k] <= '0;
        for (int j = 0; j < 3; j++) prod_p0[k][j] <= '0;
      end
      mode_p0 <= '0;
      sync_p0 <= '0;
      vld_p0  <= 1'b0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        add_p0[k] <= add[k];
        for (int j = 0; j < 3; j++) prod_p0[k][j] <= cf[k][j] * x[j];
      end
      mode_p0 <= cur_mode;
      sync_p0 <= {per_frame_vsync, per_frame_href, per_frame_clken};
      vld_p0  <= per_frame_href & per_frame_clken;
    end
  end

  // ---- S2: sums ----
  logic signed [IW-1:0] sum_p1 [3];
  logic [3:0]           mode_p1;
  logic [2:0]           sync_p1;
  logic                 vld_p1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) sum_p1[k] <= '0;
      mode_p1 <= '0;
      sync_p1 <= '0;
      vld_p1  <= 1'b0;
    end else begin
      for (int k = 0; k < 3; k++)
        sum_p1[k] <= prod_p0[k][0] + prod_p0[k][1] + prod_p0[k][2] + add_p0[k];
      mode_p1 <= mode_p0;
      sync_p1 <= sync_p0;
      vld_p1  <= vld_p0;
    end
  end

  // ---- S3: round, shift, saturate, gate ----
  logic signed [IW-1:0] res [3];

  always_comb begin
    for (int k = 0; k < 3; k++) res[k] = round_shift(sum_p1[k]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      post_img_c0      <= '0;
      post_img_c1      <= '0;
      post_img_c2      <= '0;
      post_img_mode    <= '0;
      post_frame_vsync <= 1'b0;
      post_frame_href  <= 1'b0;
      post_frame_clken <= 1'b0;
    end else begin
      post_img_c0   <= vld_p1 ? saturate(res[0]) : '0;
      post_img_c1   <= vld_p1 ? saturate(res[1]) : '0;
      post_img_c2   <= vld_p1 ? saturate(res[2]) : '0;
      post_img_mode <= mode_p1;
      {post_frame_vsync, post_frame_href, post_frame_clken} <= sync_p1;
    end
  end

`ifdef CSC_FRAME_STATS_EN
  function automatic logic clipped(input logic signed [IW-1:0] v);
    return v[IW-1] || (v > MAXV);
  endfunction

  logic        sat_p2;
  logic        post_vsync_q;
  logic [15:0] sat_cnt;
  logic [15:0] stat_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sat_p2       <= 1'b0;
      post_vsync_q <= 1'b0;
      sat_cnt      <= '0;
      stat_q       <= '0;
    end else begin
      sat_p2       <= vld_p1 & (clipped(res[0]) | clipped(res[1]) | clipped(res[2]));
      post_vsync_q <= post_frame_vsync;
      if (post_vsync_q & ~post_frame_vsync) begin
        stat_q  <= sat_cnt;
        sat_cnt <= sat_p2 ? 16'd1 : 16'd0;
      end else if (sat_p2 && sat_cnt != 16'hFFFF) begin
        sat_cnt <= sat_cnt + 16'd1;
      end
    end
  end

  assign stat_sat_cnt = stat_q;
`else
  assign stat_sat_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_csc_multimode_pipe.sv
`timescale 1ns/1ps
module tb_csc_multimode_pipe;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          vsync, href, clken;
  logic [3:0]    mode;
  logic [DW-1:0] c0, c1, c2;
  logic          post_frame_vsync, post_frame_href, post_frame_clken;
  logic [3:0]    post_img_mode;
  logic [DW-1:0] post_img_c0, post_img_c1, post_img_c2;
  logic [15:0]   stat_sat_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  csc_multimode_pipe #(.DW(DW), .MODE_DEFAULT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .per_frame_vsync(vsync), .per_frame_href(href), .per_frame_clken(clken),
    .per_img_mode(mode), .per_img_c0(c0), .per_img_c1(c1), .per_img_c2(c2),
    .post_frame_vsync(post_frame_vsync), .post_frame_href(post_frame_href),
    .post_frame_clken(post_frame_clken), .post_img_mode(post_img_mode),
    .post_img_c0(post_img_c0), .post_img_c1(post_img_c1), .post_img_c2(post_img_c2),
    .stat_sat_cnt(stat_sat_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                       input logic h, input logic k);
    c0 = a; c1 = b; c2 = c; href = h; clken = k;
  endtask

  task automatic idle();
    drive(8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
  endtask

  function automatic logic [23:0] outs();
    return {post_img_c0, post_img_c1, post_img_c2};
  endfunction

  task automatic start_frame(input logic [3:0] m);
    idle();
    mode = m; vsync = 1'b1;
    tick();
    vsync = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; vsync = 1'b1; mode = 4'd2;
    drive(8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b1);
    tick(); tick();
    checks++; if (outs() !== 24'h0) begin errors++; $display("FAIL reset_data: got %h want 000000", outs()); end
    checks++; if ({post_frame_vsync, post_frame_href, post_frame_clken} !== 3'b000) begin
      errors++; $display("FAIL reset_sync: got %b want 000", {post_frame_vsync, post_frame_href, post_frame_clken}); end
    checks++; if (post_img_mode !== 4'd0) begin errors++; $display("FAIL reset_mode: got %0d want 0", post_img_mode); end
    checks++; if (stat_sat_cnt !== 16'd0) begin errors++; $display("FAIL reset_stat: got %0d want 0", stat_sat_cnt); end
    idle(); vsync = 1'b0; mode = 4'd1;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_rgb2ycc();
    start_frame(4'd1);
    drive(8'd255, 8'd255, 8'd255, 1'b1, 1'b1); tick();
    drive(8'd255, 8'd0, 8'd0, 1'b1, 1'b1); tick();
    idle();
    checks++; if (outs() !== 24'h0) begin errors++; $display("FAIL t1_not_early: got %h want 000000", outs()); end
    tick();
    checks++; if (outs() !== 24'hFF8080) begin errors++; $display("FAIL t1_white: got %h want ff8080", outs()); end
    checks++; if ({post_img_mode, post_frame_href, post_frame_clken} !== {4'd1, 2'b11}) begin
      errors++; $display("FAIL t1_mode_sync: got %h want 7", {post_img_mode, post_frame_href, post_frame_clken}); end
    tick();
    checks++; if (outs() !== 24'h4D55FF) begin errors++; $display("FAIL t1_red_clamp: got %h want 4d55ff", outs()); end
  endtask

  task automatic test_ycc2rgb();
    start_frame(4'd2);
    drive(8'd128, 8'd128, 8'd128, 1'b1, 1'b1); tick();
    drive(8'd255, 8'd128, 8'd255, 1'b1, 1'b1); tick();
    idle(); tick();
    checks++; if (outs() !== 24'h808080) begin errors++; $display("FAIL t2_grey: got %h want 808080", outs()); end
    checks++; if (post_img_mode !== 4'd2) begin errors++; $display("FAIL t2_mode: got %0d want 2", post_img_mode); end
    tick();
    checks++; if (outs() !== 24'hFFA4FF) begin errors++; $display("FAIL t2_magenta: got %h want ffa4ff", outs()); end
  endtask

  task automatic test_gray();
    start_frame(4'd3);
    drive(8'd255, 8'd0, 8'd0, 1'b1, 1'b1); tick();
    idle(); tick(); tick();
    checks++; if (outs() !== 24'h4D4D4D) begin errors++; $display("FAIL t3_gray: got %h want 4d4d4d", outs()); end
    checks++; if (post_img_mode !== 4'd3) begin errors++; $display("FAIL t3_mode: got %0d want 3", post_img_mode); end
  endtask

  task automatic test_mode_switch();
    start_frame(4'd1);
    mode = 4'd2;
    drive(8'd255, 8'd0, 8'd0, 1'b1, 1'b1); tick();
    idle(); tick(); tick();
    checks++; if ({outs(), post_img_mode} !== {24'h4D55FF, 4'd1}) begin
      errors++; $display("FAIL t4_midframe_a: got %h want 4d55ff1", {outs(), post_img_mode}); end
    tick();
    drive(8'd255, 8'd255, 8'd255, 1'b1, 1'b1); tick();
    idle(); tick(); tick();
    checks++; if ({outs(), post_img_mode} !== {24'hFF8080, 4'd1}) begin
      errors++; $display("FAIL t4_midframe_b: got %h want ff80801", {outs(), post_img_mode}); end
    start_frame(4'd2);
    drive(8'd128, 8'd128, 8'd255, 1'b1, 1'b1); tick();
    idle(); tick(); tick();
    checks++; if ({outs(), post_img_mode} !== {24'hFF2580, 4'd2}) begin
      errors++; $display("FAIL t4_next_frame: got %h want ff25802", {outs(), post_img_mode}); end
    start_frame(4'd9);
    drive(8'd10, 8'd20, 8'd30, 1'b1, 1'b1); tick();
    idle(); tick(); tick();
    checks++; if ({outs(), post_img_mode} !== {24'h0A141E, 4'd0}) begin
      errors++; $display("FAIL t4_illegal_bypass: got %h want 0a141e0", {outs(), post_img_mode}); end
  endtask

  task automatic test_gating();
    drive(8'd10, 8'd20, 8'd30, 1'b1, 1'b0); tick();
    drive(8'd10, 8'd20, 8'd30, 1'b0, 1'b1); tick();
    idle(); tick();
    checks++; if ({outs(), post_frame_href, post_frame_clken} !== {24'h0, 2'b10}) begin
      errors++; $display("FAIL gate_noclken: got %h want 2", {outs(), post_frame_href, post_frame_clken}); end
    tick();
    checks++; if ({outs(), post_frame_href, post_frame_clken} !== {24'h0, 2'b01}) begin
      errors++; $display("FAIL gate_nohref: got %h want 1", {outs(), post_frame_href, post_frame_clken}); end
  endtask

  task automatic test_sync();
    idle(); vsync = 1'b1; tick();
    vsync = 1'b0; tick();
    checks++; if (post_frame_vsync !== 1'b0) begin errors++; $display("FAIL vsync_early: got %b want 0", post_frame_vsync); end
    tick();
    checks++; if (post_frame_vsync !== 1'b1) begin errors++; $display("FAIL vsync_delay3: got %b want 1", post_frame_vsync); end
    tick();
    checks++; if (post_frame_vsync !== 1'b0) begin errors++; $display("FAIL vsync_fall: got %b want 0", post_frame_vsync); end
  endtask

  task automatic test_reset_midline();
    start_frame(4'd3);
    drive(8'd255, 8'd0, 8'd0, 1'b1, 1'b1); tick();
    drive(8'd0, 8'd255, 8'd0, 1'b1, 1'b1); tick();
    rst_n = 1'b0; tick();
    checks++; if ({outs(), post_img_mode, post_frame_href} !== 29'h0) begin
      errors++; $display("FAIL t5_reset_outs: got %h want 0", {outs(), post_img_mode, post_frame_href}); end
    idle(); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if ({outs(), post_frame_href, post_frame_clken} !== 26'h0) begin
        errors++; $display("FAIL t5_stale_%0d: got %h want 0", i, {outs(), post_frame_href, post_frame_clken}); end
    end
    drive(8'd255, 8'd0, 8'd0, 1'b1, 1'b1); tick();
    idle(); tick(); tick();
    checks++; if ({outs(), post_img_mode} !== {24'h4D55FF, 4'd1}) begin
      errors++; $display("FAIL t5_default_mode: got %h want 4d55ff1", {outs(), post_img_mode}); end
  endtask

  task automatic test_stats();
    logic [15:0] want;
`ifdef CSC_FRAME_STATS_EN
    want = 16'd4;
`else
    want = 16'd0;
`endif
    start_frame(4'd1);
    for (int i = 0; i < 5; i++) tick();
    for (int i = 0; i < 10; i++) begin
      if (i % 3 == 0) drive(8'd255, 8'd0, 8'd0, 1'b1, 1'b1);
      else            drive(8'd128, 8'd128, 8'd128, 1'b1, 1'b1);
      tick();
    end
    idle();
    for (int i = 0; i < 4; i++) tick();
    vsync = 1'b1; tick();
    vsync = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    checks++; if (stat_sat_cnt !== want) begin
      errors++; $display("FAIL t6_stat_cnt: got %0d want %0d", stat_sat_cnt, want); end
  endtask

  initial begin
    test_reset();
    test_rgb2ycc();
    test_ycc2rgb();
    test_gray();
    test_mode_switch();
    test_gating();
    test_sync();
    test_reset_midline();
    test_stats();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
